// File: rtl/npu_ram_load_ctrl.sv
// Host line-load sequencer and NPU_ram write arbiter between the AXI host path and NPU_alu.
// Drives N_ram_selector's select, write enable and line index; state is exposed on state_o.
module npu_ram_load_ctrl #(
    parameter int LINE_W  = 4,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_start_i,
    input  logic [LINE_W-1:0] load_lines_i,
    input  logic              beat_valid_i,
    output logic              beat_ready_o,
    input  logic              npu_req_i,
    output logic              npu_gnt_o,
    output logic              ram_sel_o,
    output logic              en_w_o,
    output logic [LINE_W-1:0] w_line_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_NPU  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

    state_t            state, state_nx;
    logic              pend, pend_nx;
    logic [LINE_W-1:0] pend_cnt, pend_cnt_nx;
    logic [LINE_W-1:0] lines, lines_nx;
    logic [LINE_W-1:0] w_line_nx;
    logic [TMO_W-1:0]  tmo, tmo_nx;
    logic              err_nx;
    logic              beat;
    logic              capture;

    // Handshake: a beat transfers in any cycle where beat_valid_i and beat_ready_o are both 1;
    // that same condition is the host write enable into N_ram_selector.
    assign beat    = beat_valid_i & beat_ready_o;
    assign en_w_o  = beat;
    assign state_o = state;

    // A start that cannot launch immediately is parked; a second parked start is dropped.
    assign capture = load_start_i & ((state != S_IDLE) | npu_req_i);

    always_comb begin
        state_nx    = state;
        pend_nx     = pend;
        pend_cnt_nx = pend_cnt;
        lines_nx    = lines;
        w_line_nx   = w_line_o;
        tmo_nx      = tmo;
        err_nx      = 1'b0;

        case (state)
            S_IDLE: begin
                if (npu_req_i) begin
                    state_nx = S_NPU;
                end else if (load_start_i | pend) begin
                    state_nx  = S_LOAD;
                    lines_nx  = load_start_i ? load_lines_i : pend_cnt;
                    pend_nx   = 1'b0;
                    w_line_nx = '0;
                    tmo_nx    = '0;
                end
            end
            S_LOAD: begin
                if (beat) begin
                    tmo_nx = '0;
                    if (w_line_o == lines) begin
                        state_nx  = S_DONE;
                        w_line_nx = '0;
                    end else begin
                        w_line_nx = w_line_o + LINE_W'(1);
                    end
                end else if (tmo == TMO_LAST) begin
                    state_nx  = S_IDLE;
                    err_nx    = 1'b1;
                    w_line_nx = '0;
                    tmo_nx    = '0;
                end else begin
                    tmo_nx = tmo + TMO_W'(1);
                end
            end
            S_NPU: begin
                if (!npu_req_i) state_nx = S_IDLE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        if (capture) begin
            if (pend) begin
                err_nx = 1'b1;
            end else begin
                pend_nx     = 1'b1;
                pend_cnt_nx = load_lines_i;
            end
        end
    end

    // Outputs are registered decodes of the next state, so they line up with the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            pend         <= 1'b0;
            pend_cnt     <= '0;
            lines        <= '0;
            tmo          <= '0;
            w_line_o     <= '0;
            beat_ready_o <= 1'b0;
            npu_gnt_o    <= 1'b0;
            ram_sel_o    <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state        <= state_nx;
            pend         <= pend_nx;
            pend_cnt     <= pend_cnt_nx;
            lines        <= lines_nx;
            tmo          <= tmo_nx;
            w_line_o     <= w_line_nx;
            beat_ready_o <= (state_nx == S_LOAD);
            npu_gnt_o    <= (state_nx == S_NPU);
            ram_sel_o    <= (state_nx == S_NPU);
            busy_o       <= (state_nx != S_IDLE);
            done_o       <= (state_nx == S_DONE);
            err_o        <= err_nx;
        end
    end

endmodule

// File: tb/tb_npu_ram_load_ctrl.sv
// Bench for npu_ram_load_ctrl: per-cycle vector table plus hand-written timeout and reset sequences.
module tb_npu_ram_load_ctrl;

    localparam int TMO_MAX = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_start = 1'b0;
    logic [3:0] load_lines = '0;
    logic       beat_valid = 1'b0;
    logic       npu_req = 1'b0;
    logic       beat_ready, npu_gnt, ram_sel, en_w, busy, done, err;
    logic [3:0] w_line;
    logic [1:0] state_dbg;
    logic [10:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    npu_ram_load_ctrl #(.LINE_W(4), .TMO_W(8), .TMO_MAX(TMO_MAX)) dut (
        .clk_i(clk), .rst_i(rst),
        .load_start_i(load_start), .load_lines_i(load_lines),
        .beat_valid_i(beat_valid), .beat_ready_o(beat_ready),
        .npu_req_i(npu_req), .npu_gnt_o(npu_gnt), .ram_sel_o(ram_sel),
        .en_w_o(en_w), .w_line_o(w_line),
        .busy_o(busy), .done_o(done), .err_o(err), .state_o(state_dbg)
    );

    // {ready, en_w, w_line[3:0], done, err, busy, gnt, sel}
    assign outs = {beat_ready, en_w, w_line, done, err, busy, npu_gnt, ram_sel};

    typedef struct {
        string      tag;
        logic       start;
        logic [3:0] lines;
        logic       valid;
        logic       req;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string tag, logic st, logic [3:0] ln, logic v, logic rq,
                                logic rdy, logic en, logic [3:0] wl, logic dn, logic er,
                                logic bz, logic gs);
        vec_t r;
        r.tag   = tag;
        r.start = st;
        r.lines = ln;
        r.valid = v;
        r.req   = rq;
        r.exp   = {rdy, en, wl, dn, er, bz, gs, gs};
        vecs.push_back(r);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(logic st, logic [3:0] ln, logic v, logic rq);
        @(negedge clk);
        load_start = st;
        load_lines = ln;
        beat_valid = v;
        npu_req    = rq;
        #1;
    endtask

    task automatic run_rows(int first, int last);
        for (int i = first; i <= last; i++) begin
            drive(vecs[i].start, vecs[i].lines, vecs[i].valid, vecs[i].req);
            check(vecs[i].tag, 32'(outs), 32'(vecs[i].exp));
        end
    endtask

    initial begin
        int err_first;
        int err_cnt;
        int done_cnt;

        //    tag        st ln v  rq  rdy en line dn er bz gs
        // Single load of 4 lines, valid held high.
        add("t1_start",  1, 3, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        add("t1_b0",     0, 0, 1, 0,  1, 1, 0, 0, 0, 1, 0);
        add("t1_b1",     0, 0, 1, 0,  1, 1, 1, 0, 0, 1, 0);
        add("t1_b2",     0, 0, 1, 0,  1, 1, 2, 0, 0, 1, 0);
        add("t1_b3",     0, 0, 1, 0,  1, 1, 3, 0, 0, 1, 0);
        add("t1_done",   0, 0, 1, 0,  0, 0, 0, 1, 0, 1, 0);
        add("t1_idle",   0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        // Gapped beats, 2 lines.
        add("t2_start",  1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        add("t2_b0",     0, 0, 1, 0,  1, 1, 0, 0, 0, 1, 0);
        add("t2_gap0",   0, 0, 0, 0,  1, 0, 1, 0, 0, 1, 0);
        add("t2_gap1",   0, 0, 0, 0,  1, 0, 1, 0, 0, 1, 0);
        add("t2_b1",     0, 0, 1, 0,  1, 1, 1, 0, 0, 1, 0);
        add("t2_done",   0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0);
        add("t2_idle",   0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        // Start collides with NPU request; load runs after release.
        add("t3_start",  1, 2, 0, 1,  0, 0, 0, 0, 0, 0, 0);
        add("t3_npu0",   0, 0, 1, 1,  0, 0, 0, 0, 0, 1, 1);
        add("t3_npu1",   0, 0, 1, 1,  0, 0, 0, 0, 0, 1, 1);
        add("t3_rel",    0, 0, 1, 0,  0, 0, 0, 0, 0, 1, 1);
        add("t3_idle",   0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        add("t3_b0",     0, 0, 1, 0,  1, 1, 0, 0, 0, 1, 0);
        add("t3_b1",     0, 0, 1, 0,  1, 1, 1, 0, 0, 1, 0);
        add("t3_b2",     0, 0, 1, 0,  1, 1, 2, 0, 0, 1, 0);
        add("t3_done",   0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0);
        add("t3_idle2",  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        // Two extra starts during LOAD: first pends, second is dropped with err.
        add("t5_start",  1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        add("t5_b0",     1, 2, 1, 0,  1, 1, 0, 0, 0, 1, 0);
        add("t5_drop",   1, 5, 0, 0,  1, 0, 1, 0, 0, 1, 0);
        add("t5_b1",     0, 0, 1, 0,  1, 1, 1, 0, 1, 1, 0);
        add("t5_done",   0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0);
        add("t5_idle",   0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        add("t5_p0",     0, 0, 1, 0,  1, 1, 0, 0, 0, 1, 0);
        add("t5_p1",     0, 0, 1, 0,  1, 1, 1, 0, 0, 1, 0);
        add("t5_p2",     0, 0, 1, 0,  1, 1, 2, 0, 0, 1, 0);
        add("t5_pdone",  0, 0, 0, 0,  0, 0, 0, 1, 0, 1, 0);
        add("t5_pidle",  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);

        // Clock/reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", 32'(outs), 32'd0);
        check("reset_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;

        run_rows(0, vecs.size() - 1);

        // Timeout: no beats after start.
        drive(1, 3, 0, 0);
        err_first = -1;
        err_cnt   = 0;
        done_cnt  = 0;
        for (int k = 1; k <= TMO_MAX + 40; k++) begin
            drive(0, 0, 0, 0);
            if (err) begin
                err_cnt++;
                if (err_first < 0) err_first = k;
            end
            if (done) done_cnt++;
        end
        check("t4_err_cycle", 32'(err_first), 32'(TMO_MAX + 1));
        check("t4_err_count", 32'(err_cnt), 32'd1);
        check("t4_no_done", 32'(done_cnt), 32'd0);
        check("t4_idle_outs", 32'(outs), 32'd0);
        check("t4_idle_state", 32'(state_dbg), 32'd0);

        // Reset mid-load after 2 of 8 beats, with a parked start to be discarded.
        drive(1, 7, 1, 0);
        drive(1, 4, 1, 0);
        check("t6_b0", 32'(outs), 32'({1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
        drive(0, 0, 1, 0);
        check("t6_b1", 32'(outs), 32'({1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_rst_outs", 32'(outs), 32'd0);
        err_cnt  = 0;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 1, 0);
            if (err) err_cnt++;
            if (done) done_cnt++;
            if (busy) err_cnt++;
        end
        check("t6_quiet", 32'({done_cnt[15:0], err_cnt[15:0]}), 32'd0);
        run_rows(0, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
